// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: write-pending scoreboard for the 32x32 register file.
// Counts in-flight writes per architectural register. ID allocates a
// destination on issue and WB releases it on writeback. ID stalls while a
// source operand still has a write pending, or while the destination counter
// is full.
//
// Optional feature: define SCOREBOARD_WB_BYPASS_EN to let a source whose last
// pending write retires this cycle issue without stalling. REGFILE forwards
// the WB data in that same cycle.
//
// Ports:
//   dclk, rst_n                    clock (rising edge), async active-low reset
//   rdy_i                          global ready; 0 freezes all state
//   flush_i                        synchronous clear of all pending state
//   re1_ID_i/raddr1_ID_i           source 1 read enable / address
//   re2_ID_i/raddr2_ID_i           source 2 read enable / address
//   alloc_ID_i/alloc_addr_ID_i     issue of an instruction writing alloc_addr
//   we_WB_i/waddr_WB_i             writeback retire of waddr
//   stall_ID_o                     combinational ID hold (alloc not accepted)
//   tot_pend_o                     registered total outstanding writes (saturating)
//   err_o                          registered sticky retire-without-pending error
module regfile_scoreboard #(
    parameter int unsigned PEND_W = 2,
    parameter int unsigned TOT_W  = 4
) (
    input  logic             dclk,
    input  logic             rst_n,
    input  logic             rdy_i,
    input  logic             flush_i,
    input  logic             re1_ID_i,
    input  logic [4:0]       raddr1_ID_i,
    input  logic             re2_ID_i,
    input  logic [4:0]       raddr2_ID_i,
    input  logic             alloc_ID_i,
    input  logic [4:0]       alloc_addr_ID_i,
    input  logic             we_WB_i,
    input  logic [4:0]       waddr_WB_i,
    output logic             stall_ID_o,
    output logic [TOT_W-1:0] tot_pend_o,
    output logic             err_o
);

    localparam int unsigned NREG = 32;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam logic [TOT_W-1:0]  TOT_MAX  = '1;

    logic [PEND_W-1:0] cnt [NREG];

    logic busy1, busy2, sat;
    logic alloc_acc, ret_acc, pair, inc, ret_eff, ret_err;
    logic [TOT_W-1:0] tot_next;

    // Source hazard detection; x0 is never busy.
    always_comb begin
        busy1 = re1_ID_i && (raddr1_ID_i != 5'd0) && (cnt[raddr1_ID_i] != '0);
        busy2 = re2_ID_i && (raddr2_ID_i != 5'd0) && (cnt[raddr2_ID_i] != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
        // Last pending write retiring now: REGFILE forwards it, so no hazard.
        if (we_WB_i && (waddr_WB_i == raddr1_ID_i) && (cnt[raddr1_ID_i] == PEND_ONE))
            busy1 = 1'b0;
        if (we_WB_i && (waddr_WB_i == raddr2_ID_i) && (cnt[raddr2_ID_i] == PEND_ONE))
            busy2 = 1'b0;
`endif
        sat = alloc_ID_i && (alloc_addr_ID_i != 5'd0) && (cnt[alloc_addr_ID_i] == PEND_MAX);
    end

    assign stall_ID_o = busy1 | busy2 | sat;

    // Accepted alloc/retire qualification. An alloc and a retire to the same
    // register cancel out: no count change and no error.
    always_comb begin
        alloc_acc = alloc_ID_i && !stall_ID_o && rdy_i && (alloc_addr_ID_i != 5'd0);
        ret_acc   = we_WB_i && rdy_i && (waddr_WB_i != 5'd0);
        pair      = alloc_acc && ret_acc && (alloc_addr_ID_i == waddr_WB_i);
        inc       = alloc_acc && !pair;
        ret_eff   = ret_acc && !pair && (cnt[waddr_WB_i] != '0);
        ret_err   = ret_acc && !pair && (cnt[waddr_WB_i] == '0);
    end

    // Net change of the total counter, saturating at both ends.
    always_comb begin
        tot_next = tot_pend_o;
        case ({inc, ret_eff})
            2'b10:   if (tot_pend_o != TOT_MAX) tot_next = tot_pend_o + TOT_W'(1);
            2'b01:   if (tot_pend_o != '0)      tot_next = tot_pend_o - TOT_W'(1);
            default: tot_next = tot_pend_o;
        endcase
    end

    // Per-register pending counters.
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
        end else if (rdy_i) begin
            if (flush_i) begin
                for (int i = 0; i < NREG; i++) cnt[i] <= '0;
            end else begin
                if (inc)     cnt[alloc_addr_ID_i] <= cnt[alloc_addr_ID_i] + PEND_ONE;
                if (ret_eff) cnt[waddr_WB_i]      <= cnt[waddr_WB_i] - PEND_ONE;
            end
        end
    end

    // Total outstanding writes and sticky error; flush keeps the error.
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            tot_pend_o <= '0;
            err_o      <= 1'b0;
        end else if (rdy_i) begin
            if (flush_i) begin
                tot_pend_o <= '0;
            end else begin
                tot_pend_o <= tot_next;
                if (ret_err) err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus a
// randomized run against a behavioural reference model.
module tb_regfile_scoreboard;

    localparam int PMAX = 3;   // 2**PEND_W-1 for PEND_W=2
    localparam int TMAX = 15;  // 2**TOT_W-1 for TOT_W=4

    logic       dclk = 1'b0;
    logic       rst_n;
    logic       rdy_i, flush_i;
    logic       re1_ID_i, re2_ID_i, alloc_ID_i, we_WB_i;
    logic [4:0] raddr1_ID_i, raddr2_ID_i, alloc_addr_ID_i, waddr_WB_i;
    logic       stall_ID_o;
    logic [3:0] tot_pend_o;
    logic       err_o;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int m_cnt [32];
    int m_tot;
    bit m_err;

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_scoreboard #(.PEND_W(2), .TOT_W(4)) dut (
        .dclk(dclk), .rst_n(rst_n), .rdy_i(rdy_i), .flush_i(flush_i),
        .re1_ID_i(re1_ID_i), .raddr1_ID_i(raddr1_ID_i),
        .re2_ID_i(re2_ID_i), .raddr2_ID_i(raddr2_ID_i),
        .alloc_ID_i(alloc_ID_i), .alloc_addr_ID_i(alloc_addr_ID_i),
        .we_WB_i(we_WB_i), .waddr_WB_i(waddr_WB_i),
        .stall_ID_o(stall_ID_o), .tot_pend_o(tot_pend_o), .err_o(err_o)
    );

    always #5 dclk = ~dclk;

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_tot = 0;
        m_err = 1'b0;
    endfunction

    function automatic bit m_busy(bit re, int ra);
        bit b;
        b = re && ra != 0 && m_cnt[ra] > 0;
        if (BYP && we_WB_i && int'(waddr_WB_i) == ra && m_cnt[ra] == 1) b = 1'b0;
        return b;
    endfunction

    function automatic bit m_stall();
        bit sat;
        sat = alloc_ID_i && alloc_addr_ID_i != 0 && m_cnt[alloc_addr_ID_i] == PMAX;
        return m_busy(re1_ID_i, int'(raddr1_ID_i)) || m_busy(re2_ID_i, int'(raddr2_ID_i)) || sat;
    endfunction

    // Applies the current inputs to the model as one clock edge would.
    function automatic void m_step(bit stall);
        bit acc, ret;
        int a, w, delta;
        if (!rdy_i) return;
        if (flush_i) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            m_tot = 0;
            return;
        end
        a = int'(alloc_addr_ID_i);
        w = int'(waddr_WB_i);
        acc = alloc_ID_i && !stall && a != 0;
        ret = we_WB_i && w != 0;
        if (acc && ret && a == w) return;
        delta = 0;
        if (acc) begin m_cnt[a]++; delta++; end
        if (ret) begin
            if (m_cnt[w] > 0) begin m_cnt[w]--; delta--; end
            else m_err = 1'b1;
        end
        m_tot += delta;
        if (m_tot > TMAX) m_tot = TMAX;
        if (m_tot < 0) m_tot = 0;
    endfunction

    task automatic idle();
        rdy_i = 1'b1; flush_i = 1'b0;
        re1_ID_i = 1'b0; raddr1_ID_i = '0; re2_ID_i = 1'b0; raddr2_ID_i = '0;
        alloc_ID_i = 1'b0; alloc_addr_ID_i = '0; we_WB_i = 1'b0; waddr_WB_i = '0;
    endtask

    task automatic drive(bit re1, int ra1, bit re2, int ra2, bit al, int aa, bit we, int wa);
        re1_ID_i = re1; raddr1_ID_i = 5'(ra1);
        re2_ID_i = re2; raddr2_ID_i = 5'(ra2);
        alloc_ID_i = al; alloc_addr_ID_i = 5'(aa);
        we_WB_i = we; waddr_WB_i = 5'(wa);
        #1;
    endtask

    // One rising edge with the model following along; returns 1 ns after it.
    task automatic tick();
        bit s;
        s = m_stall();
        @(posedge dclk);
        m_step(s);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        m_reset();
        @(posedge dclk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_reset();
        for (int k = 0; k < 4; k++) begin
            rdy_i = 1'($urandom); flush_i = 1'($urandom);
            drive(1'($urandom), int'($urandom_range(31)), 1'($urandom), int'($urandom_range(31)),
                  1'($urandom), int'($urandom_range(31)), 1'($urandom), int'($urandom_range(31)));
            @(posedge dclk);
            #1;
            checks++;
            if (stall_ID_o !== 1'b0 || tot_pend_o !== 4'd0 || err_o !== 1'b0) begin
                errors++;
                $display("FAIL reset: stall=%b tot=%0d err=%b required 0/0/0", stall_ID_o, tot_pend_o, err_o);
            end
        end
        idle();
        rst_n = 1'b1;
        #1;
        // Asynchronous reset between edges.
        drive(0, 0, 0, 0, 1, 2, 0, 0);
        tick();
        drive(1, 2, 0, 0, 0, 0, 0, 0);
        checks++;
        if (stall_ID_o !== 1'b1) begin
            errors++; $display("FAIL async_pre: stall=%b required 1", stall_ID_o);
        end
        #1 rst_n = 1'b0;
        m_reset();
        #1;
        checks++;
        if (stall_ID_o !== 1'b0 || tot_pend_o !== 4'd0) begin
            errors++; $display("FAIL async_reset: stall=%b tot=%0d required 0/0", stall_ID_o, tot_pend_o);
        end
        do_reset();
    endtask

    task automatic test_bypass();
        do_reset();
        drive(0, 0, 0, 0, 1, 5, 0, 0);
        tick();
        drive(1, 5, 0, 0, 0, 0, 0, 0);
        checks++;
        if (stall_ID_o !== 1'b1) begin
            errors++; $display("FAIL raw_stall: stall=%b required 1", stall_ID_o);
        end
        tick();
        drive(1, 5, 0, 0, 0, 0, 1, 5);
        checks++;
        if (stall_ID_o !== !BYP) begin
            errors++; $display("FAIL wb_bypass: stall=%b required %b", stall_ID_o, !BYP);
        end
        tick();
        drive(1, 5, 1, 5, 0, 0, 0, 0);
        checks++;
        if (stall_ID_o !== 1'b0 || tot_pend_o !== 4'd0) begin
            errors++; $display("FAIL after_wb: stall=%b tot=%0d required 0/0", stall_ID_o, tot_pend_o);
        end
        tick();
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 1, 7, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 1, 7, 0, 0);
        checks++;
        if (stall_ID_o !== 1'b1 || tot_pend_o !== 4'd3) begin
            errors++; $display("FAIL sat: stall=%b tot=%0d required 1/3", stall_ID_o, tot_pend_o);
        end
        tick();
        checks++;
        if (tot_pend_o !== 4'd3) begin
            errors++; $display("FAIL sat_hold: tot=%0d required 3", tot_pend_o);
        end
        // Three retires drain x7 exactly; a wrapped counter would error.
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 7);
            tick();
        end
        drive(1, 7, 0, 0, 0, 0, 0, 0);
        checks++;
        if (stall_ID_o !== 1'b0 || tot_pend_o !== 4'd0 || err_o !== 1'b0) begin
            errors++; $display("FAIL sat_drain: stall=%b tot=%0d err=%b required 0/0/0", stall_ID_o, tot_pend_o, err_o);
        end
    endtask

    task automatic test_err();
        do_reset();
        drive(0, 0, 0, 0, 1, 9, 1, 9);
        tick();
        checks++;
        if (err_o !== 1'b0 || tot_pend_o !== 4'd0) begin
            errors++; $display("FAIL pair_zero: err=%b tot=%0d required 0/0", err_o, tot_pend_o);
        end
        drive(0, 0, 0, 0, 1, 3, 1, 9);
        tick();
        checks++;
        if (err_o !== 1'b1 || tot_pend_o !== 4'd1) begin
            errors++; $display("FAIL underflow: err=%b tot=%0d required 1/1", err_o, tot_pend_o);
        end
        drive(1, 9, 0, 0, 1, 9, 1, 9);
        tick();
        drive(1, 9, 0, 0, 0, 0, 0, 0);
        checks++;
        if (err_o !== 1'b1 || tot_pend_o !== 4'd1 || stall_ID_o !== 1'b0) begin
            errors++; $display("FAIL err_sticky: err=%b tot=%0d stall=%b required 1/1/0", err_o, tot_pend_o, stall_ID_o);
        end
    endtask

    task automatic test_x0();
        do_reset();
        drive(1, 0, 1, 0, 1, 0, 0, 0);
        checks++;
        if (stall_ID_o !== 1'b0) begin
            errors++; $display("FAIL x0_stall: stall=%b required 0", stall_ID_o);
        end
        tick();
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        tick();
        checks++;
        if (tot_pend_o !== 4'd0 || err_o !== 1'b0 || stall_ID_o !== 1'b0) begin
            errors++; $display("FAIL x0_track: tot=%0d err=%b stall=%b required 0/0/0", tot_pend_o, err_o, stall_ID_o);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(0, 0, 0, 0, 1, 3, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 4, 0, 0);
        tick();
        rdy_i = 1'b0;
        drive(1, 3, 0, 0, 1, 5, 1, 4);
        checks++;
        if (stall_ID_o !== 1'b1) begin
            errors++; $display("FAIL frozen_stall: stall=%b required 1", stall_ID_o);
        end
        tick();
        drive(0, 0, 0, 0, 1, 5, 1, 4);
        tick();
        checks++;
        if (tot_pend_o !== 4'd2) begin
            errors++; $display("FAIL freeze: tot=%0d required 2", tot_pend_o);
        end
        rdy_i = 1'b1;
        flush_i = 1'b1;
        drive(0, 0, 0, 0, 1, 6, 1, 3);
        tick();
        flush_i = 1'b0;
        drive(1, 3, 1, 4, 0, 0, 0, 0);
        checks++;
        if (stall_ID_o !== 1'b0 || tot_pend_o !== 4'd0) begin
            errors++; $display("FAIL flush: stall=%b tot=%0d required 0/0", stall_ID_o, tot_pend_o);
        end
        drive(1, 6, 0, 0, 0, 0, 0, 0);
        checks++;
        if (stall_ID_o !== 1'b0 || err_o !== 1'b0) begin
            errors++; $display("FAIL flush_discard: stall=%b err=%b required 0/0", stall_ID_o, err_o);
        end
    endtask

    task automatic test_random();
        bit exp_s;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            rdy_i   = ($urandom_range(9) != 0);
            flush_i = ($urandom_range(40) == 0);
            drive(1'($urandom), int'($urandom_range(7)), 1'($urandom), int'($urandom_range(7)),
                  ($urandom_range(2) != 0), int'($urandom_range(7)),
                  ($urandom_range(2) == 0), int'($urandom_range(7)));
            exp_s = m_stall();
            checks++;
            if (stall_ID_o !== exp_s) begin
                errors++; $display("FAIL rnd_stall[%0d]: stall=%b required %b", k, stall_ID_o, exp_s);
            end
            tick();
            checks++;
            if (int'(tot_pend_o) != m_tot || err_o !== m_err) begin
                errors++; $display("FAIL rnd_state[%0d]: tot=%0d err=%b required %0d/%b", k, tot_pend_o, err_o, m_tot, m_err);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        m_reset();
        @(negedge dclk);
        test_reset();
        test_bypass();
        test_saturate();
        test_err();
        test_x0();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
